// File: rtl/four_bit_sequential_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_sequential_divider_if
// Description : Operand/result bundle and start/busy/done handshake between
//               the ALU controller (master) and the sequential divider (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface four_bit_sequential_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/four_bit_sequential_divider.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_sequential_divider
// Description : Multi-cycle unsigned restoring divider. One shift-and-trial-
//               subtract step per clock; divide-by-zero short-circuits to a
//               saturated quotient and flags div_by_zero.
// Revision    : 1.0 - initial release
// ============================================================================
module four_bit_sequential_divider #(
    parameter int WIDTH = 4
) (
    input  wire logic                           clk,
    input  wire logic                           rst_n,
    four_bit_sequential_divider_if.slave        io_div
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_rem_work;
    logic [WIDTH-1:0]   r_quo_work;
    logic [WIDTH-1:0]   r_divisor;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dbz;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_quo_step;
    logic               w_last_step;
    logic               w_div_zero;

    // One restoring-division step: shift {R,Q} left, trial-subtract D, keep or restore.
    always_comb begin
        w_shift     = {r_rem_work, r_quo_work[WIDTH-1]};
        w_trial     = w_shift - {1'b0, r_divisor};
        w_last_step = (r_cnt == CNT_W'(WIDTH - 1));
        w_div_zero  = (io_div.divisor == '0);
        if (!w_trial[WIDTH]) begin
            w_rem_step = w_trial[WIDTH-1:0];
            w_quo_step = {r_quo_work[WIDTH-2:0], 1'b1};
        end else begin
            // A borrow means the shifted remainder was below D, so it fits in WIDTH bits.
            w_rem_step = w_shift[WIDTH-1:0];
            w_quo_step = {r_quo_work[WIDTH-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: DONE always lasts exactly one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (io_div.start) begin
                    w_state_next = w_div_zero ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_last_step) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Working registers and result registers; results only update on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem_work  <= '0;
            r_quo_work  <= '0;
            r_divisor   <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_div.start) begin
                        if (!w_div_zero) begin
                            r_rem_work <= '0;
                            r_quo_work <= io_div.dividend;
                            r_divisor  <= io_div.divisor;
                            r_cnt      <= '0;
                        end else begin
                            r_quotient  <= '1;
                            r_remainder <= io_div.dividend;
                            r_dbz       <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    r_rem_work <= w_rem_step;
                    r_quo_work <= w_quo_step;
                    r_cnt      <= r_cnt + 1'b1;
                    if (w_last_step) begin
                        r_quotient  <= w_quo_step;
                        r_remainder <= w_rem_step;
                        r_dbz       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_div.quotient    = r_quotient;
    assign io_div.remainder   = r_remainder;
    assign io_div.div_by_zero = r_dbz;
    assign io_div.busy        = (r_state != ST_IDLE);
    assign io_div.done        = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_four_bit_sequential_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_four_bit_sequential_divider
// Description : Self-checking bench for four_bit_sequential_divider with an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_four_bit_sequential_divider;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    four_bit_sequential_divider_if #(.WIDTH(WIDTH)) dif ();

    four_bit_sequential_divider #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_div (dif)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int prev_q  = 0;
    int prev_r  = 0;
    int prev_z  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r, output int z);
        if (b == 0) begin
            q = MAXV;
            r = a;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endfunction

    // Issue one operation from IDLE and check latency, results and the single done pulse.
    task automatic run_op(input int a, input int b, input bit hold, input string tag);
        int eq, er, ez, lat;
        ref_div(a, b, eq, er, ez);
        lat = 0;
        while (dif.busy !== 1'b0 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " idle"}, 32'(dif.busy), 0);
        dif.start    = 1'b1;
        dif.dividend = a[WIDTH-1:0];
        dif.divisor  = b[WIDTH-1:0];
        tick();
        if (!hold) dif.start = 1'b0;
        dif.dividend = WIDTH'($urandom);
        dif.divisor  = WIDTH'($urandom);
        if (b != 0) begin
            check({tag, " hold q"}, 32'(dif.quotient), prev_q);
            check({tag, " hold r"}, 32'(dif.remainder), prev_r);
            check({tag, " hold z"}, 32'(dif.div_by_zero), prev_z);
            check({tag, " busy calc"}, 32'(dif.busy), 1);
        end
        lat = 0;
        while (dif.done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, (b == 0) ? 0 : WIDTH);
        check({tag, " quotient"}, 32'(dif.quotient), eq);
        check({tag, " remainder"}, 32'(dif.remainder), er);
        check({tag, " dbz"}, 32'(dif.div_by_zero), ez);
        check({tag, " busy done"}, 32'(dif.busy), 1);
        prev_q = eq;
        prev_r = er;
        prev_z = ez;
        tick();
        check({tag, " done pulse"}, 32'(dif.done), 0);
        check({tag, " busy after"}, 32'(dif.busy), 0);
    endtask

    // Global time limit so a stuck DUT cannot hang the run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed steps followed by an exhaustive back-to-back sweep and random operations.
    initial begin
        int ndone, q, r;
        rst_n        = 1'b0;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (2) tick();
        check("reset q", 32'(dif.quotient), 0);
        check("reset r", 32'(dif.remainder), 0);
        check("reset z", 32'(dif.div_by_zero), 0);
        check("reset busy", 32'(dif.busy), 0);
        check("reset done", 32'(dif.done), 0);
        rst_n = 1'b1;
        tick();

        run_op(13, 3, 1'b0, "13/3");
        run_op(15, 1, 1'b0, "15/1");
        run_op(7, 9, 1'b0, "7/9");
        run_op(0, 5, 1'b0, "0/5");
        run_op(9, 0, 1'b0, "9/0");

        // start pulsed while busy must be ignored.
        dif.start = 1'b1; dif.dividend = 4'd12; dif.divisor = 4'd5;
        tick();
        dif.start = 1'b0;
        tick();
        dif.start = 1'b1; dif.dividend = 4'd2; dif.divisor = 4'd1;
        tick();
        dif.start = 1'b0;
        ndone = 0; q = -1; r = -1;
        for (int i = 0; i < 12; i++) begin
            if (dif.done === 1'b1) begin
                ndone++;
                q = int'(dif.quotient);
                r = int'(dif.remainder);
            end
            tick();
        end
        check("ignore start done count", ndone, 1);
        check("ignore start q", q, 2);
        check("ignore start r", r, 2);
        prev_q = 2; prev_r = 2; prev_z = 0;

        // Reset on the second CALC edge aborts the operation.
        dif.start = 1'b1; dif.dividend = 4'd14; dif.divisor = 4'd3;
        tick();
        dif.start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("abort q", 32'(dif.quotient), 0);
        check("abort r", 32'(dif.remainder), 0);
        check("abort z", 32'(dif.div_by_zero), 0);
        check("abort busy", 32'(dif.busy), 0);
        check("abort done", 32'(dif.done), 0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dif.done === 1'b1) ndone++;
        end
        check("abort no done", ndone, 0);
        prev_q = 0; prev_r = 0; prev_z = 0;
        run_op(14, 3, 1'b0, "14/3 after abort");

        // All operand pairs back-to-back with start held high.
        for (int a = 0; a <= MAXV; a++) begin
            for (int b = 0; b <= MAXV; b++) begin
                run_op(a, b, 1'b1, $sformatf("sweep %0d/%0d", a, b));
            end
        end
        dif.start = 1'b0;
        tick();
        tick();

        // Random operands with random idle gaps.
        for (int k = 0; k < 60; k++) begin
            int a, b;
            a = int'($urandom_range(0, MAXV));
            b = int'($urandom_range(0, MAXV));
            repeat ($urandom_range(0, 2)) tick();
            run_op(a, b, 1'b0, $sformatf("rand %0d/%0d", a, b));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
